// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared register-file constants and the write-port scheduler state type.
package mips_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 32;

    typedef enum logic [0:0] {
        ARB  = 1'b0,
        HOLD = 1'b1
    } sched_state_t;

endpackage

// File: rtl/regfile_wb_scheduler_scoreboard.sv
// Reservation scoreboard for long-latency destinations: busy bits, in-flight count
// and the decode hazard compare (without the pipeline-hold term).
module regfile_scoreboard
    import mips_pkg::*;
#(
    parameter int MAX_PENDING = 4,
    localparam int CNT_W      = $clog2(MAX_PENDING + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic                  issue_long,
    input  logic [REG_ADDR_W-1:0] issue_rs,
    input  logic [REG_ADDR_W-1:0] issue_rt,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic                  hold,
    input  logic                  release_en,
    input  logic [REG_ADDR_W-1:0] release_addr,
    output logic                  hazard,
    output logic [CNT_W-1:0]      pending_cnt
);

    logic [NUM_REGS-1:0] busy_r;
    logic [NUM_REGS-1:0] busy_nxt_s;
    logic [CNT_W-1:0]    pending_r;
    logic [CNT_W-1:0]    pending_nxt_s;
    logic                full_s;
    logic                reserve_s;

    // Hazard compare uses registered busy bits only, so a release never bypasses.
    always_comb begin
        full_s    = (pending_r == CNT_W'(MAX_PENDING));
        hazard    = issue_valid & (busy_r[issue_rs] | busy_r[issue_rt] | busy_r[issue_rd] |
                                   (issue_long & full_s));
        reserve_s = issue_valid & issue_long & ~hazard & ~hold;
    end

    // Next reservation state: release first, then reserve; r0 is never tracked.
    always_comb begin
        busy_nxt_s    = busy_r;
        pending_nxt_s = pending_r;
        if (release_en) begin
            busy_nxt_s[release_addr] = 1'b0;
        end else begin
            busy_nxt_s = busy_r;
        end
        if (reserve_s) begin
            busy_nxt_s[issue_rd] = 1'b1;
        end else begin
            busy_nxt_s[issue_rd] = busy_nxt_s[issue_rd];
        end
        busy_nxt_s[0] = 1'b0;
        case ({reserve_s, release_en})
            2'b10: pending_nxt_s = pending_r + CNT_W'(1);
            2'b01: begin
                // A stray retirement with nothing in flight leaves the count at zero.
                if (pending_r != {CNT_W{1'b0}}) begin
                    pending_nxt_s = pending_r - CNT_W'(1);
                end else begin
                    pending_nxt_s = pending_r;
                end
            end
            default: pending_nxt_s = pending_r;
        endcase
    end

    // Reservation state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_r    <= {NUM_REGS{1'b0}};
            pending_r <= {CNT_W{1'b0}};
        end else begin
            busy_r    <= busy_nxt_s;
            pending_r <= pending_nxt_s;
        end
    end

    assign pending_cnt = pending_r;

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Shares the register-file write port between pipeline writeback and the long unit,
// with a starvation guard that freezes the pipeline for one cycle.
module regfile_wb_scheduler
    import mips_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int MAX_PENDING  = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               pipe_wr_en,
    input  logic [REG_ADDR_W-1:0]              pipe_wr_addr,
    input  logic [DATA_W-1:0]                  pipe_wr_data,
    input  logic                               lu_valid,
    input  logic [REG_ADDR_W-1:0]              lu_addr,
    input  logic [DATA_W-1:0]                  lu_data,
    output logic                               lu_ready,
    input  logic                               issue_valid,
    input  logic                               issue_long,
    input  logic [REG_ADDR_W-1:0]              issue_rs,
    input  logic [REG_ADDR_W-1:0]              issue_rt,
    input  logic [REG_ADDR_W-1:0]              issue_rd,
    output logic                               stall,
    output logic                               pipe_hold,
    output logic                               wr_en3,
    output logic [REG_ADDR_W-1:0]              wr_addr3,
    output logic [DATA_W-1:0]                  wr_data3,
    output logic [$clog2(MAX_PENDING+1)-1:0]   pending_cnt
);

    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

    sched_state_t      state_r;
    sched_state_t      state_nxt_s;
    logic [WAIT_W-1:0] wait_r;
    logic [WAIT_W-1:0] wait_nxt_s;
    logic              pipe_hold_r;
    logic              lu_ready_s;
    logic              use_lu_s;
    logic              wr_en_s;
    logic              hazard_s;

    regfile_scoreboard #(
        .MAX_PENDING (MAX_PENDING)
    ) u_sb (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (issue_valid),
        .issue_long   (issue_long),
        .issue_rs     (issue_rs),
        .issue_rt     (issue_rt),
        .issue_rd     (issue_rd),
        .hold         (pipe_hold_r),
        .release_en   (lu_valid & lu_ready_s),
        .release_addr (lu_addr),
        .hazard       (hazard_s),
        .pending_cnt  (pending_cnt)
    );

    // Arbitration and starvation tracking; the pipeline wins unless we are holding it.
    always_comb begin
        state_nxt_s = state_r;
        wait_nxt_s  = wait_r;
        lu_ready_s  = 1'b0;
        use_lu_s    = 1'b0;
        wr_en_s     = 1'b0;
        case (state_r)
            ARB: begin
                lu_ready_s = ~pipe_wr_en;
                use_lu_s   = ~pipe_wr_en;
                wr_en_s    = pipe_wr_en | lu_valid;
                if (lu_valid & pipe_wr_en) begin
                    if (wait_r == WAIT_W'(STARVE_LIMIT - 1)) begin
                        state_nxt_s = HOLD;
                        wait_nxt_s  = {WAIT_W{1'b0}};
                    end else begin
                        wait_nxt_s = wait_r + WAIT_W'(1);
                    end
                end else begin
                    wait_nxt_s = {WAIT_W{1'b0}};
                end
            end
            HOLD: begin
                lu_ready_s  = 1'b1;
                use_lu_s    = 1'b1;
                wr_en_s     = lu_valid;
                state_nxt_s = ARB;
                wait_nxt_s  = {WAIT_W{1'b0}};
            end
            default: begin
                state_nxt_s = ARB;
                wait_nxt_s  = {WAIT_W{1'b0}};
            end
        endcase
    end

    // Port outputs are combinational but forced quiet while reset is asserted.
    always_comb begin
        if (rst) begin
            lu_ready = lu_ready_s;
            wr_en3   = wr_en_s;
            wr_addr3 = use_lu_s ? lu_addr : pipe_wr_addr;
            wr_data3 = use_lu_s ? lu_data : pipe_wr_data;
            stall    = hazard_s | (issue_valid & pipe_hold_r);
        end else begin
            lu_ready = 1'b0;
            wr_en3   = 1'b0;
            wr_addr3 = {REG_ADDR_W{1'b0}};
            wr_data3 = {DATA_W{1'b0}};
            stall    = 1'b0;
        end
    end

    // Scheduler state, refusal counter and the registered hold flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ARB;
            wait_r      <= {WAIT_W{1'b0}};
            pipe_hold_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            wait_r      <= wait_nxt_s;
            pipe_hold_r <= (state_nxt_s == HOLD);
        end
    end

    assign pipe_hold = pipe_hold_r;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed and randomized checks of the write-port scheduler against a
// cycle-level behavioural model of the arbitration and reservation rules.
module tb_regfile_wb_scheduler;

    localparam int STARVE_LIMIT = 4;
    localparam int MAX_PENDING  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pipe_wr_en = 1'b0;
    logic [4:0]  pipe_wr_addr = 5'd0;
    logic [31:0] pipe_wr_data = 32'd0;
    logic        lu_valid = 1'b0;
    logic [4:0]  lu_addr = 5'd0;
    logic [31:0] lu_data = 32'd0;
    logic        lu_ready;
    logic        issue_valid = 1'b0;
    logic        issue_long = 1'b0;
    logic [4:0]  issue_rs = 5'd0;
    logic [4:0]  issue_rt = 5'd0;
    logic [4:0]  issue_rd = 5'd0;
    logic        stall;
    logic        pipe_hold;
    logic        wr_en3;
    logic [4:0]  wr_addr3;
    logic [31:0] wr_data3;
    logic [2:0]  pending_cnt;

    regfile_wb_scheduler #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .MAX_PENDING  (MAX_PENDING)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pipe_wr_en   (pipe_wr_en),
        .pipe_wr_addr (pipe_wr_addr),
        .pipe_wr_data (pipe_wr_data),
        .lu_valid     (lu_valid),
        .lu_addr      (lu_addr),
        .lu_data      (lu_data),
        .lu_ready     (lu_ready),
        .issue_valid  (issue_valid),
        .issue_long   (issue_long),
        .issue_rs     (issue_rs),
        .issue_rt     (issue_rt),
        .issue_rd     (issue_rd),
        .stall        (stall),
        .pipe_hold    (pipe_hold),
        .wr_en3       (wr_en3),
        .wr_addr3     (wr_addr3),
        .wr_data3     (wr_data3),
        .pending_cnt  (pending_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: which registers are reserved, how many ops are in flight,
    // how long the current lu result has been refused, and whether a hold is due.
    bit         m_busy [32];
    int         m_pend;
    int         m_refused;
    bit         m_hold;
    int         m_age;
    bit         last_hs;
    bit         last_reserve;
    logic [4:0] lq [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic model_reset();
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_pend    = 0;
        m_refused = 0;
        m_hold    = 1'b0;
        m_age     = 0;
        lq.delete();
    endtask

    task automatic zero_inputs();
        pipe_wr_en = 1'b0; pipe_wr_addr = 5'd0; pipe_wr_data = 32'd0;
        lu_valid = 1'b0; lu_addr = 5'd0; lu_data = 32'd0;
        issue_valid = 1'b0; issue_long = 1'b0;
        issue_rs = 5'd0; issue_rt = 5'd0; issue_rd = 5'd0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        zero_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    // One clock cycle: drive, compare against the model, then advance the model.
    task automatic cycle(input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                         input logic lv, input logic [4:0] la, input logic [31:0] ld,
                         input logic iv, input logic il,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        bit          exp_ready, exp_wen, exp_stall, hazard;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
        @(negedge clk);
        pipe_wr_en = pwe; pipe_wr_addr = pa; pipe_wr_data = pd;
        lu_valid = lv; lu_addr = la; lu_data = ld;
        issue_valid = iv; issue_long = il; issue_rs = rs; issue_rt = rt; issue_rd = rd;
        #1;
        exp_ready = m_hold ? 1'b1 : !pwe;
        exp_wen   = m_hold ? lv : (pwe | lv);
        exp_addr  = (m_hold || !pwe) ? la : pa;
        exp_data  = (m_hold || !pwe) ? ld : pd;
        hazard    = m_busy[rs] | m_busy[rt] | m_busy[rd] | (il && m_pend == MAX_PENDING);
        exp_stall = iv && (hazard || m_hold);
        check_eq("pipe_hold", 32'(pipe_hold), 32'(m_hold));
        check_eq("lu_ready", 32'(lu_ready), 32'(exp_ready));
        check_eq("wr_en3", 32'(wr_en3), 32'(exp_wen));
        if (exp_wen) begin
            check_eq("wr_addr3", 32'(wr_addr3), 32'(exp_addr));
            check_eq("wr_data3", wr_data3, exp_data);
        end
        check_eq("stall", 32'(stall), 32'(exp_stall));
        check_eq("pending_cnt", 32'(pending_cnt), 32'(m_pend));
        if (lu_valid && lu_ready) begin
            assert (pending_cnt != 3'd0) else $error("lu handshake with nothing pending");
            assert (lu_addr == 5'd0 || dut.u_sb.busy_r[lu_addr]) else $error("lu handshake clears idle register");
        end
        last_hs      = lv && exp_ready;
        last_reserve = iv && il && !exp_stall;
        if (lv) begin
            if (last_hs) begin
                check_eq("lu_latency_ok", 32'(m_age <= STARVE_LIMIT), 32'd1);
                m_age = 0;
            end else begin
                m_age++;
            end
        end else begin
            m_age = 0;
        end
        if (last_hs) begin
            if (la != 5'd0) m_busy[la] = 1'b0;
            if (m_pend > 0) m_pend--;
        end
        if (last_reserve) begin
            m_pend++;
            if (rd != 5'd0) m_busy[rd] = 1'b1;
        end
        // The STARVE_LIMIT-th consecutive refusal schedules a hold for the next cycle.
        if (m_hold) begin
            m_hold = 1'b0;
            m_refused = 0;
        end else if (lv && !exp_ready) begin
            m_refused++;
            if (m_refused == STARVE_LIMIT) begin
                m_hold = 1'b1;
                m_refused = 0;
            end
        end else begin
            m_refused = 0;
        end
    endtask

    bit          lu_act;
    logic [4:0]  lu_a;
    logic [31:0] lu_d;

    initial begin
        model_reset();
        #1;
        check_eq("rst_wr_en3", 32'(wr_en3), 32'd0);
        check_eq("rst_pending", 32'(pending_cnt), 32'd0);
        do_reset();

        // Pipeline priority over a waiting long-unit result.
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd7);
        cycle(1'b1, 5'd5, 32'hAAAA0000, 1'b1, 5'd7, 32'h7777, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        check_eq("prio_pipe_addr", 32'(wr_addr3), 32'd5);
        check_eq("prio_pipe_ready", 32'(lu_ready), 32'd0);
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h7777, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        check_eq("prio_lu_addr", 32'(wr_addr3), 32'd7);
        check_eq("prio_lu_ready", 32'(lu_ready), 32'd1);

        // Starvation: forced hold in the fifth refused cycle.
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd9);
        for (int k = 1; k <= 6; k++) begin
            cycle(1'b1, 5'd11, 32'(k), (k <= 5), 5'd9, 32'h1234, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
            check_eq($sformatf("starve_hold_c%0d", k), 32'(pipe_hold), 32'(k == 5));
            if (k == 5) begin
                check_eq("starve_addr", 32'(wr_addr3), 32'd9);
                check_eq("starve_data", wr_data3, 32'h1234);
                check_eq("starve_ready", 32'(lu_ready), 32'd1);
            end
        end

        // RAW hazard on r3 until its retirement edge.
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd3);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd3, 5'd0, 5'd4);
        check_eq("raw_stall_wait", 32'(stall), 32'd1);
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h33, 1'b1, 1'b0, 5'd3, 5'd0, 5'd4);
        check_eq("raw_stall_hs", 32'(stall), 32'd1);
        check_eq("raw_pend_hs", 32'(pending_cnt), 32'd1);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd3, 5'd0, 5'd4);
        check_eq("raw_stall_after", 32'(stall), 32'd0);
        check_eq("raw_pend_after", 32'(pending_cnt), 32'd0);

        // Capacity limit.
        for (int k = 1; k <= 4; k++)
            cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'd0, 5'd0, 5'(k));
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'd6, 5'd7, 5'd5);
        check_eq("cap_pend", 32'(pending_cnt), 32'd4);
        check_eq("cap_long_stall", 32'(stall), 32'd1);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd9, 5'd10, 5'd8);
        check_eq("cap_short_stall", 32'(stall), 32'd0);
        for (int k = 1; k <= 4; k++)
            cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'(k), 32'(k), 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);

        // Simultaneous reserve r10 / release r2, then a long op to r0.
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd2);
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 32'h22, 1'b1, 1'b1, 5'd0, 5'd0, 5'd10);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0);
        check_eq("simul_pend", 32'(pending_cnt), 32'd1);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd10, 5'd0, 5'd0);
        check_eq("simul_r10_busy", 32'(stall), 32'd1);
        check_eq("simul_r0_counted", 32'(pending_cnt), 32'd2);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd2, 5'd0, 5'd0);
        check_eq("simul_r2_free", 32'(stall), 32'd0);

        // Reset while holding with two ops in flight.
        for (int k = 1; k <= 5; k++)
            cycle(1'b1, 5'd12, 32'hC, 1'b1, 5'd10, 32'hA0, 1'b1, 1'b0, 5'd10, 5'd0, 5'd0);
        check_eq("mid_in_hold", 32'(pipe_hold), 32'd1);
        rst = 1'b0;
        #1;
        check_eq("mid_rst_lu_ready", 32'(lu_ready), 32'd0);
        check_eq("mid_rst_wr_en3", 32'(wr_en3), 32'd0);
        check_eq("mid_rst_wr_addr3", 32'(wr_addr3), 32'd0);
        check_eq("mid_rst_wr_data3", wr_data3, 32'd0);
        check_eq("mid_rst_stall", 32'(stall), 32'd0);
        check_eq("mid_rst_hold", 32'(pipe_hold), 32'd0);
        check_eq("mid_rst_pend", 32'(pending_cnt), 32'd0);
        zero_inputs();
        #1;
        rst = 1'b1;
        model_reset();
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'd10, 5'd0, 5'd10);
        check_eq("post_rst_stall", 32'(stall), 32'd0);

        // Randomized traffic with a well-behaved long unit serving reservations in order.
        do_reset();
        lu_act = 1'b0;
        lu_a   = 5'd0;
        lu_d   = 32'd0;
        for (int c = 0; c < 800; c++) begin
            logic [4:0] rd;
            if (!lu_act && lq.size() > 0 && $urandom_range(0, 1) == 1) begin
                lu_act = 1'b1;
                lu_a   = lq[0];
                lu_d   = $urandom;
            end
            rd = 5'($urandom_range(0, 7));
            cycle(($urandom_range(0, 9) < ((c < 400) ? 5 : 9)), 5'($urandom_range(0, 31)), $urandom,
                  lu_act, lu_a, lu_d,
                  1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), rd);
            if (last_hs) begin
                void'(lq.pop_front());
                lu_act = 1'b0;
            end
            if (last_reserve) lq.push_back(rd);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_wb_scheduler.md
# regfile_wb_scheduler

Write-port scheduler and scoreboard for the 32×32 register file. It shares the file's single write port (wr_en3/wr_addr3/wr_data3) between the in-order pipeline writeback and a long-latency unit (mult/div), which uses a valid/ready handshake. It tracks registers reserved by in-flight long-latency ops and stalls decode on RAW/WAW hazards. A starvation guard forces a one-cycle pipeline hold so that long-unit results always retire.

## Interface
- STARVE_LIMIT, 4: consecutive refused lu_valid cycles before a forced hold (≥2)
- MAX_PENDING, 4: maximum in-flight long-latency ops
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-low reset
- pipe_wr_en  in  1  pipeline writeback request
- pipe_wr_addr  in  5  pipeline destination register
- pipe_wr_data  in  32  pipeline result
- lu_valid  in  1  long-unit result valid
- lu_addr  in  5  long-unit destination register
- lu_data  in  32  long-unit result
- lu_ready  out  1  long-unit result accepted this cycle
- issue_valid  in  1  decode presents an instruction
- issue_long  in  1  instruction goes to the long unit
- issue_rs, issue_rt, issue_rd  in  5 each  source and destination addresses
- stall  out  1  decode must hold the instruction
- pipe_hold  out  1  pipeline must freeze this cycle, WB stage included
- wr_en3, wr_addr3, wr_data3  out  1/5/32  register-file write port
- pending_cnt  out  3  in-flight long ops (width clog2(MAX_PENDING+1))

## Operation
- **FSM states:** ARB and HOLD. Reset puts the FSM in ARB.
  - ARB→HOLD when lu_valid=1, lu_ready=0 and wait_cnt==STARVE_LIMIT-1.
  - HOLD→ARB unconditionally after one cycle.
- **Arbitration in ARB:**
  - The pipeline has priority. lu_ready = !pipe_wr_en.
  - When pipe_wr_en=1, the port carries the pipe fields.
  - When pipe_wr_en=0, lu_valid drives wr_en3 and the port carries the lu fields.
- **Arbitration in HOLD:**
  - pipe_hold=1, lu_ready=1, and the port carries the lu fields.
  - pipe_wr_en is ignored. The frozen pipeline re-presents the same write next cycle.
- **wait_cnt (internal):**
  - Increments on each ARB cycle with lu_valid & !lu_ready.
  - Clears on a lu handshake, in HOLD, or when lu_valid=0.
- **Scoreboard busy[31:0] (registered):**
  - Reserve: on issue_valid & issue_long & !stall with issue_rd≠0, set busy[issue_rd] and increment pending_cnt.
  - Release: on a lu handshake (lu_valid & lu_ready), clear busy[lu_addr] and decrement pending_cnt.
  - Reserve and release in the same cycle leave pending_cnt unchanged.
  - busy[0] is always 0. A long op with rd=0 still counts in pending_cnt.
- **stall:** issue_valid & (busy[issue_rs] | busy[issue_rt] | busy[issue_rd] | (issue_long & pending_cnt==MAX_PENDING) | pipe_hold).
  - stall uses registered busy only. A register released this cycle still stalls; there is no same-cycle bypass.
- **Protocol errors:** a lu handshake with pending_cnt==0 leaves the count at 0, and clearing a non-busy bit is a no-op. The bench flags both via assertion.
- Addresses and data pass through unmodified, including r0 writes; the register file masks r0 on read.

## Timing
- The write port, lu_ready and stall are combinational from inputs and registered state, with zero latency. The register file commits on the next posedge.
- pipe_hold is a registered output: high for exactly the one HOLD cycle.
- A starving lu result retires within at most STARVE_LIMIT+1 cycles of first assertion of lu_valid.
- A busy bit set at edge N stalls a dependent issue from cycle N onward. Release at edge M unblocks at cycle M.
- **Reset, asynchronous with rst=0:**
  - busy=0, pending_cnt=0, wait_cnt=0, FSM=ARB, pipe_hold=0.
  - Combinational outputs are forced to wr_en3=0, lu_ready=0, stall=0, with wr_addr3/wr_data3 = 0.
  - Reset mid-operation discards all reservations. The long unit is reset with the same rst.
- **Back-to-back hold:** a new HOLD cannot occur earlier than STARVE_LIMIT cycles after the previous one.

## Structure
- Shared package mips_pkg holds:
  - REG_ADDR_W=5, DATA_W=32, NUM_REGS=32.
  - The FSM enum sched_state_t {ARB, HOLD}.
- Sub-module regfile_scoreboard contains busy[], pending_cnt and the hazard compare; it outputs stall without the pipe_hold term.
- Top level: arbitration mux, FSM, wait_cnt.

## Test plan
- **Priority:** pipe_wr_en=1 (r5, 0xAAAA0000) with lu_valid=1 (r7) → port writes r5, lu_ready=0. Next cycle with pipe_wr_en=0 → r7 written, lu_ready=1.
- **Starvation:** STARVE_LIMIT=4, pipe_wr_en=1 continuously, lu_valid=1 (r9, 0x1234) → pipe_hold=1 in cycle 5. In that cycle the port writes r9=0x1234 and lu_ready=1; pipe_hold=0 after.
- **RAW hazard:** issue long rd=r3, then issue_rs=r3 → stall=1 until the r3 handshake edge; stall=0 the following cycle, and pending_cnt goes 1→0.
- **Capacity:** issue 4 long ops (r1–r4) with no retirement → pending_cnt=4. A 5th long issue stalls, while a non-long issue with independent regs does not stall.
- **Simultaneous events:** in the same cycle, reserve r10 and release r2 → pending_cnt unchanged, busy[10]=1, busy[2]=0. A long issue with rd=0 sets no busy bit and increments the count.
- **Reset mid-operation:** with 2 pending ops and the FSM in HOLD, pulse rst=0 → all outputs are 0 immediately. After release, FSM=ARB, pending_cnt=0, and no stalls.
